// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// General-purpose event/timebase counter. It generalises the plain 4-bit up
// counter in width, terminal value, direction, wrap/saturate behaviour and
// step rate. It also provides synchronous load and clear, a one-cycle boundary
// pulse and a sticky boundary flag. With default parameters and up_down held
// at 1, it behaves cycle-for-cycle like the 4-bit up counter.
//
// Parameters:
//   WIDTH     count width in bits (1..32)
//   MAX_VAL   terminal (highest) count value, 1..2**WIDTH-1
//   SATURATE  0 = wrap at the boundaries, 1 = hold at the boundaries
//   STEP_DIV  enabled cycles per count step (1..256)
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   enable      count enable (also advances the prescaler)
//   up_down     1 = count up, 0 = count down; sampled at the step edge
//   clear       synchronous clear of count and prescaler
//   load        synchronous load of load_value, clamped to MAX_VAL
//   load_value  value to load
//   ovf_clr     clears sticky_ovf
//   count       current count (registered)
//   ovf         one-cycle pulse after a boundary event (registered)
//   sticky_ovf  latched boundary event flag (registered)
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             sticky_ovf
);

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             sticky_r;

  logic             presc_hit_s;
  logic             step_s;
  logic             boundary_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] load_clamped_s;

  // Prescaler. A step fires on the enabled edge where the prescaler holds
  // STEP_DIV-1. With STEP_DIV=1 every enabled cycle is a step, so no
  // prescaler register is built.
  generate
    if (STEP_DIV > 1) begin : g_presc
      localparam int unsigned PW = $clog2(STEP_DIV);
      logic [PW-1:0] presc_r;

      assign presc_hit_s = (presc_r == PW'(STEP_DIV - 1));

      // Prescale counter: reset, clear and load discard partial progress;
      // enable=0 freezes it.
      always_ff @(posedge clk) begin
        if (reset || clear || load) begin
          presc_r <= '0;
        end else if (enable) begin
          if (presc_hit_s) begin
            presc_r <= '0;
          end else begin
            presc_r <= presc_r + PW'(1'b1);
          end
        end else begin
          presc_r <= presc_r;
        end
      end
    end else begin : g_no_presc
      assign presc_hit_s = 1'b1;
    end
  endgenerate

  // A step happens only when no higher-priority action (clear or load) owns
  // this edge.
  assign step_s = enable & ~clear & ~load & presc_hit_s;

  // Clamp out-of-range load values to the terminal value. Do not truncate them.
  assign load_clamped_s = (load_value > MAX_VAL) ? MAX_VAL : load_value;

  // Next-count and boundary detection. Compare against MAX_VAL and 0
  // explicitly. Never rely on natural WIDTH-bit rollover.
  always_comb begin
    count_nxt_s = count_r;
    boundary_s  = 1'b0;
    if (step_s) begin
      if (up_down) begin
        if (count_r == MAX_VAL) begin
          boundary_s  = 1'b1;
          count_nxt_s = SATURATE ? count_r : '0;
        end else begin
          count_nxt_s = count_r + WIDTH'(1'b1);
        end
      end else begin
        if (count_r == '0) begin
          boundary_s  = 1'b1;
          count_nxt_s = SATURATE ? count_r : MAX_VAL;
        end else begin
          count_nxt_s = count_r - WIDTH'(1'b1);
        end
      end
    end else begin
      count_nxt_s = count_r;
      boundary_s  = 1'b0;
    end
  end

  // Count and boundary pulse, with priority reset > clear > load > counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else if (load) begin
      count_r <= load_clamped_s;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= boundary_s;
    end
  end

  // Sticky boundary flag. It is set on any boundary event, and set wins over
  // ovf_clr. Clear and load leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= boundary_s | (sticky_r & ~ovf_clr);
    end
  end

  assign count      = count_r;
  assign ovf        = ovf_r;
  assign sticky_ovf = sticky_r;

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//
// Directed bench for param_updown_counter. All four instances share one clock
// and one set of inputs:
//   u_def  defaults (WIDTH=4, MAX_VAL=15, wrap, STEP_DIV=1)
//   u_wrap MAX_VAL=9, wrap
//   u_sat  MAX_VAL=9, saturate
//   u_div  defaults with STEP_DIV=3
// Each step checks the instance that the current scenario targets. Inputs are
// driven 1 time unit after the rising edge, and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       ovf_clr;

  logic [3:0] def_count, wrap_count, sat_count, div_count;
  logic       def_ovf, wrap_ovf, sat_ovf, div_ovf;
  logic       def_sticky, wrap_sticky, sat_sticky, div_sticky;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_updown_counter u_def (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .count(def_count), .ovf(def_ovf), .sticky_ovf(def_sticky)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .count(wrap_count), .ovf(wrap_ovf), .sticky_ovf(wrap_sticky)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .count(sat_count), .ovf(sat_ovf), .sticky_ovf(sat_sticky)
  );

  param_updown_counter #(.STEP_DIV(3)) u_div (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
    .count(div_count), .ovf(div_ovf), .sticky_ovf(div_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_cnt;
    logic [3:0] prev_cnt;
    logic       exp_ovf;
    logic       exp_sticky;

    reset = 1'b1; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
    load = 1'b0; load_value = 4'd0; ovf_clr = 1'b0;

    // 1. Reset values, then a default up-count through the 15->0 wrap.
    tick(); tick();
    chk("rst_def_count", def_count, 0);
    chk("rst_def_ovf", def_ovf, 0);
    chk("rst_def_sticky", def_sticky, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_div_count", div_count, 0);
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    exp_cnt = 4'd0; exp_sticky = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      prev_cnt   = exp_cnt;
      exp_ovf    = (prev_cnt == 4'd15);
      exp_cnt    = exp_ovf ? 4'd0 : prev_cnt + 4'd1;
      exp_sticky = exp_sticky | exp_ovf;
      chk($sformatf("up_count_%0d", i), def_count, exp_cnt);
      chk($sformatf("up_ovf_%0d", i), def_ovf, exp_ovf);
      chk($sformatf("up_sticky_%0d", i), def_sticky, exp_sticky);
    end

    // 2. MAX_VAL=9 wrap instance: load 2, count down through the 0->9 wrap, then check the load clamp.
    enable = 1'b0; load = 1'b1; load_value = 4'd2;
    tick();
    load = 1'b0;
    chk("wrap_load2", wrap_count, 2);
    up_down = 1'b0; enable = 1'b1;
    tick(); chk("wrap_dn_1", wrap_count, 1); chk("wrap_dn_1_ovf", wrap_ovf, 0);
    tick(); chk("wrap_dn_0", wrap_count, 0); chk("wrap_dn_0_ovf", wrap_ovf, 0);
    tick(); chk("wrap_dn_9", wrap_count, 9); chk("wrap_dn_9_ovf", wrap_ovf, 1);
    tick(); chk("wrap_dn_8", wrap_count, 8); chk("wrap_dn_8_ovf", wrap_ovf, 0);
    enable = 1'b0; load = 1'b1; load_value = 4'd13;
    tick();
    load = 1'b0;
    chk("wrap_load13_clamp", wrap_count, 9);
    chk("def_load13_noclamp", def_count, 13);

    // 3. Saturating instance: count up from 7 and hold at 9.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("sat_rst_sticky", sat_sticky, 0);
    load = 1'b1; load_value = 4'd7; tick(); load = 1'b0;
    chk("sat_load7", sat_count, 7);
    enable = 1'b1; up_down = 1'b1;
    tick(); chk("sat_8", sat_count, 8); chk("sat_8_ovf", sat_ovf, 0);
    tick(); chk("sat_9", sat_count, 9); chk("sat_9_ovf", sat_ovf, 0);
    tick(); chk("sat_hold_a", sat_count, 9); chk("sat_hold_a_ovf", sat_ovf, 1);
    tick(); chk("sat_hold_b", sat_count, 9); chk("sat_hold_b_ovf", sat_ovf, 1);
    tick(); chk("sat_hold_c", sat_count, 9); chk("sat_hold_c_ovf", sat_ovf, 1);
    chk("sat_sticky", sat_sticky, 1);

    // 4. STEP_DIV=3 instance: the prescaler freezes while enable=0; clear discards partial prescale progress.
    enable = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1; up_down = 1'b1;
    tick(); chk("div_e1", div_count, 0);
    enable = 1'b0;
    tick(); chk("div_frz1", div_count, 0);
    tick(); chk("div_frz2", div_count, 0);
    enable = 1'b1;
    tick(); chk("div_e2", div_count, 0);
    tick(); chk("div_e3", div_count, 1);
    tick(); chk("div_e4", div_count, 1);
    tick(); chk("div_e5", div_count, 1);
    tick(); chk("div_e6", div_count, 2);
    tick(); chk("div_e7", div_count, 2);
    clear = 1'b1;
    tick(); chk("div_clear", div_count, 0);
    clear = 1'b0;
    tick(); chk("div_c1", div_count, 0);
    tick(); chk("div_c2", div_count, 0);
    tick(); chk("div_c3", div_count, 1);

    // 5. Priority: reset > clear > load > count.
    reset = 1'b1; clear = 1'b1; load = 1'b1; load_value = 4'd5; enable = 1'b1;
    tick();
    chk("prio_reset", def_count, 0);
    reset = 1'b0;
    tick();
    chk("prio_clear", def_count, 0);
    clear = 1'b0;
    tick();
    chk("prio_load", def_count, 5);
    chk("prio_load_ovf", def_ovf, 0);
    load = 1'b0; enable = 1'b0;

    // 6. ovf_clr against a wrap on the same edge, ovf_clr alone, then reset mid-count.
    load = 1'b1; load_value = 4'd15; tick(); load = 1'b0;
    enable = 1'b1; tick();
    chk("stk_set", def_sticky, 1);
    enable = 1'b0; load = 1'b1; load_value = 4'd15; tick(); load = 1'b0;
    enable = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("stk_clr_vs_wrap_cnt", def_count, 0);
    chk("stk_clr_vs_wrap_ovf", def_ovf, 1);
    chk("stk_clr_vs_wrap", def_sticky, 1);
    enable = 1'b0;
    tick();
    chk("stk_clr_alone", def_sticky, 0);
    chk("stk_clr_alone_ovf", def_ovf, 0);
    ovf_clr = 1'b0;
    load = 1'b1; load_value = 4'd15; tick(); load = 1'b0;
    enable = 1'b1;
    tick();
    chk("mid_wrap_sticky", def_sticky, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_count6", def_count, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0; enable = 1'b0;
    chk("mid_rst_count", def_count, 0);
    chk("mid_rst_ovf", def_ovf, 0);
    chk("mid_rst_sticky", def_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
